// File: rtl/div_responder.sv
// rtl/div_responder.sv - multi-cycle 32-bit radix-2 restoring divider, responder side of the divider handshake
//
// Purpose:
//   Accepts a dividend and a divisor over two independent valid/ready channels,
//   runs 32 restoring steps, and presents {quotient, remainder} on a one-cycle
//   m_axis_dout_tvalid pulse. SIGNED=1 gives two's-complement division (DIV),
//   SIGNED=0 gives unsigned division (DIVU).
//
// Ports:
//   clk, reset                     single clock, synchronous active-high reset
//   s_axis_dividend_tdata/tvalid   dividend offer; s_axis_dividend_tready accept
//   s_axis_divisor_tdata/tvalid    divisor offer;  s_axis_divisor_tready accept
//   m_axis_dout_tdata[63:0]        {quotient, remainder}, held until next result
//   m_axis_dout_tvalid             one-cycle result pulse, no back-pressure
//   cancel                         only when DIV_CANCEL_EN is defined
//
// Configuration macro:
//   DIV_CANCEL_EN  adds the cancel input (abort in BUSY/DONE, drop half pair in IDLE)

module div_responder #(
    parameter int unsigned SIGNED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
`ifdef DIV_CANCEL_EN
    ,
    input  logic        cancel
`endif
);

    localparam bit IS_SIGNED = (SIGNED != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        dvd_got_q, dvd_got_d;
    logic        dvs_got_q, dvs_got_d;
    logic [31:0] dvd_q, dvd_d;     // raw dividend, kept for the divide-by-zero remainder
    logic [31:0] dvs_q, dvs_d;     // raw divisor while waiting in IDLE, its magnitude from BUSY on
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;     // starts as |dividend|, shifts out as quotient bits shift in
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [63:0] dout_q, dout_d;

    logic        cancel_w;
    logic        dvd_take, dvs_take;
    logic [31:0] dvd_now, dvs_now;
    logic [32:0] shifted;
    logic        trial_ge;
    logic [31:0] trial_diff;
    logic [31:0] q_fix, r_fix;
    logic [63:0] result;

`ifdef DIV_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    function automatic logic [31:0] mag(input logic [31:0] v);
        return (IS_SIGNED && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Each channel is taken the moment it is offered while IDLE and not yet held.
    assign dvd_take = (state_q == S_IDLE) && !dvd_got_q && s_axis_dividend_tvalid;
    assign dvs_take = (state_q == S_IDLE) && !dvs_got_q && s_axis_divisor_tvalid;
    assign dvd_now  = dvd_got_q ? dvd_q : s_axis_dividend_tdata;
    assign dvs_now  = dvs_got_q ? dvs_q : s_axis_divisor_tdata;

    // Restoring step. The remainder stays below the divisor, so whenever the
    // 33-bit trial is non-negative its difference fits in 32 bits and the low
    // 32 bits of a plain 32-bit subtraction are exact.
    assign shifted    = {rem_q, quo_q[31]};
    assign trial_ge   = (shifted >= {1'b0, dvs_q});
    assign trial_diff = shifted[31:0] - dvs_q;

    assign q_fix  = q_neg_q ? (~quo_q + 32'd1) : quo_q;
    assign r_fix  = r_neg_q ? (~rem_q + 32'd1) : rem_q;
    // Zero magnitude means zero divisor; that answer overrides the sign fixup.
    assign result = (dvs_q == 32'd0) ? {32'hFFFF_FFFF, dvd_q} : {q_fix, r_fix};

    assign s_axis_dividend_tready = (state_q == S_IDLE) && !dvd_got_q;
    assign s_axis_divisor_tready  = (state_q == S_IDLE) && !dvs_got_q;
    assign m_axis_dout_tvalid     = (state_q == S_DONE) && !cancel_w;
    assign m_axis_dout_tdata      = m_axis_dout_tvalid ? result : dout_q;

    always_comb begin
        state_d   = state_q;
        dvd_got_d = dvd_got_q;
        dvs_got_d = dvs_got_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dout_d    = dout_q;

        case (state_q)
            S_IDLE: begin
                if (cancel_w) begin
                    dvd_got_d = 1'b0;
                    dvs_got_d = 1'b0;
                end else if ((dvd_got_q || dvd_take) && (dvs_got_q || dvs_take)) begin
                    // Flags drop here; tready stays low anyway until IDLE returns.
                    state_d   = S_BUSY;
                    dvd_got_d = 1'b0;
                    dvs_got_d = 1'b0;
                    cnt_d     = 5'd0;
                    rem_d     = 32'd0;
                    quo_d     = mag(dvd_now);
                    dvs_d     = mag(dvs_now);
                    dvd_d     = dvd_now;
                    q_neg_d   = IS_SIGNED && (dvd_now[31] ^ dvs_now[31]);
                    r_neg_d   = IS_SIGNED && dvd_now[31];
                end else begin
                    if (dvd_take) begin
                        dvd_got_d = 1'b1;
                        dvd_d     = s_axis_dividend_tdata;
                    end
                    if (dvs_take) begin
                        dvs_got_d = 1'b1;
                        dvs_d     = s_axis_divisor_tdata;
                    end
                end
            end
            S_BUSY: begin
                if (cancel_w) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = trial_ge ? trial_diff : shifted[31:0];
                    quo_d = {quo_q[30:0], trial_ge};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!cancel_w) begin
                    dout_d = result;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dvd_got_q <= 1'b0;
            dvs_got_q <= 1'b0;
            dvd_q     <= 32'd0;
            dvs_q     <= 32'd0;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dout_q    <= 64'd0;
        end else begin
            state_q   <= state_d;
            dvd_got_q <= dvd_got_d;
            dvs_got_q <= dvs_got_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_div_responder.sv
// tb/tb_div_responder.sv - randomized and directed bench for div_responder against a cycle-count reference model

module tb_div_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] da, db;
    logic        va, vb;
`ifdef DIV_CANCEL_EN
    logic        cancel;
`endif

    logic        ra_u, rb_u, tv_u, ra_s, rb_s, tv_s;
    logic [63:0] td_u, td_s;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit checking = 1'b0;

    // Reference model: a division accepted at edge T pulses after edge T+32
    // and frees the channels after edge T+33.
    bit          m_active = 1'b0;
    bit          m_have_a = 1'b0;
    bit          m_have_b = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    int          m_T = 0;
    logic [63:0] m_res_u = '0, m_res_s = '0, m_last_u = '0, m_last_s = '0;

    always #5 clk = ~clk;

    div_responder #(.SIGNED(0)) u_dut_u (
        .clk                    (clk),
        .reset                  (rst),
        .s_axis_dividend_tdata  (da),
        .s_axis_dividend_tvalid (va),
        .s_axis_dividend_tready (ra_u),
        .s_axis_divisor_tdata   (db),
        .s_axis_divisor_tvalid  (vb),
        .s_axis_divisor_tready  (rb_u),
        .m_axis_dout_tdata      (td_u),
        .m_axis_dout_tvalid     (tv_u)
`ifdef DIV_CANCEL_EN
        ,
        .cancel                 (cancel)
`endif
    );

    div_responder #(.SIGNED(1)) u_dut_s (
        .clk                    (clk),
        .reset                  (rst),
        .s_axis_dividend_tdata  (da),
        .s_axis_dividend_tvalid (va),
        .s_axis_dividend_tready (ra_s),
        .s_axis_divisor_tdata   (db),
        .s_axis_divisor_tvalid  (vb),
        .s_axis_divisor_tready  (rb_s),
        .m_axis_dout_tdata      (td_s),
        .m_axis_dout_tvalid     (tv_s)
`ifdef DIV_CANCEL_EN
        ,
        .cancel                 (cancel)
`endif
    );

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
        sa = a;
        sb = b;
        return {32'(sa / sb), 32'(sa % sb)};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            4: return 32'd0 - 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    logic        take_a, take_b, got_a, got_b;
    logic [31:0] a_now, b_now;
    logic        exp_ra, exp_rb, exp_valid;
    logic [63:0] exp_du, exp_ds;

    assign take_a    = !m_active && !m_have_a && va;
    assign take_b    = !m_active && !m_have_b && vb;
    assign got_a     = m_have_a || take_a;
    assign got_b     = m_have_b || take_b;
    assign a_now     = m_have_a ? m_a : da;
    assign b_now     = m_have_b ? m_b : db;
    assign exp_ra    = !m_active && !m_have_a;
    assign exp_rb    = !m_active && !m_have_b;
    assign exp_valid = m_active && (edge_n == m_T + 33);
    assign exp_du    = exp_valid ? m_res_u : m_last_u;
    assign exp_ds    = exp_valid ? m_res_s : m_last_s;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_have_a <= 1'b0;
            m_have_b <= 1'b0;
            m_last_u <= '0;
            m_last_s <= '0;
        end else if (!m_active) begin
            if (got_a && got_b) begin
                m_active <= 1'b1;
                m_T      <= edge_n;
                m_res_u  <= ref_div(1'b0, a_now, b_now);
                m_res_s  <= ref_div(1'b1, a_now, b_now);
                m_have_a <= 1'b0;
                m_have_b <= 1'b0;
            end else begin
                if (take_a) begin
                    m_have_a <= 1'b1;
                    m_a      <= da;
                end
                if (take_b) begin
                    m_have_b <= 1'b1;
                    m_b      <= db;
                end
            end
        end else if (edge_n == m_T + 33) begin
            m_active <= 1'b0;
            m_last_u <= m_res_u;
            m_last_s <= m_res_s;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("dividend_tready_u", {63'd0, ra_u}, {63'd0, exp_ra});
            chk("divisor_tready_u",  {63'd0, rb_u}, {63'd0, exp_rb});
            chk("dividend_tready_s", {63'd0, ra_s}, {63'd0, exp_ra});
            chk("divisor_tready_s",  {63'd0, rb_s}, {63'd0, exp_rb});
            chk("dout_tvalid_u",     {63'd0, tv_u}, {63'd0, exp_valid});
            chk("dout_tvalid_s",     {63'd0, tv_s}, {63'd0, exp_valid});
            chk("dout_tdata_u",      td_u, exp_du);
            chk("dout_tdata_s",      td_s, exp_ds);
        end
    end

    task automatic wait_pulse(output bit seen);
        int n;
        n = 0;
        while (!tv_u && n < 40) begin
            @(negedge clk);
            n++;
        end
        seen = tv_u;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL pulse_timeout: got no dout_tvalid within 40 cycles (edge %0d)", edge_n);
        end
    endtask

    task automatic do_pair(input logic [31:0] a, input logic [31:0] b, input int d,
                           input logic [63:0] eu, input logic [63:0] es);
        int ea;
        bit seen;
        @(negedge clk);
        da = a;
        va = 1'b1;
        if (d == 0) begin
            db = b;
            vb = 1'b1;
        end
        @(negedge clk);
        ea = edge_n - 1;
        va = 1'b0;
        da = $urandom;
        if (d > 0) begin
            repeat (d - 1) @(negedge clk);
            db = b;
            vb = 1'b1;
            @(negedge clk);
        end
        vb = 1'b0;
        db = $urandom;
        wait_pulse(seen);
        if (seen) begin
            chk("latency", 64'(edge_n - 1 - ea), 64'(d + 32));
            chk("literal_u", td_u, eu);
            chk("pulse_s", {63'd0, tv_s}, 64'd1);
            chk("literal_s", td_s, es);
        end
        @(negedge clk);
    endtask

    initial begin
        int e1;
        bit seen;
        rst = 1'b1;
        va  = 1'b0;
        vb  = 1'b0;
        da  = '0;
        db  = '0;
`ifdef DIV_CANCEL_EN
        cancel = 1'b0;
`endif
        chk("model_100_7_u",   ref_div(1'b0, 32'd100, 32'd7),                {32'h0000_000E, 32'h0000_0002});
        chk("model_m7_2_s",    ref_div(1'b1, 32'hFFFF_FFF9, 32'd2),          {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        chk("model_min_m1_s",  ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF),  {32'h8000_0000, 32'h0000_0000});
        chk("model_5_0_u",     ref_div(1'b0, 32'd5, 32'd0),                  {32'hFFFF_FFFF, 32'h0000_0005});
        chk("model_7_m2_s",    ref_div(1'b1, 32'd7, 32'hFFFF_FFFE),          {32'hFFFF_FFFD, 32'h0000_0001});

        repeat (2) @(negedge clk);
        checking = 1'b1;
        chk("reset_tready_u", {63'd0, ra_u & rb_u}, 64'd1);
        chk("reset_tvalid_s", {63'd0, tv_s}, 64'd0);
        chk("reset_tdata_s",  td_s, 64'd0);
        rst = 1'b0;

        do_pair(32'd100,       32'd7,         0, {32'h0000_000E, 32'h0000_0002}, {32'h0000_000E, 32'h0000_0002});
        do_pair(32'hFFFF_FFF9, 32'd2,         0, {32'h7FFF_FFFC, 32'h0000_0001}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        do_pair(32'h8000_0000, 32'hFFFF_FFFF, 0, {32'h0000_0000, 32'h8000_0000}, {32'h8000_0000, 32'h0000_0000});
        do_pair(32'd5,         32'd0,         0, {32'hFFFF_FFFF, 32'h0000_0005}, {32'hFFFF_FFFF, 32'h0000_0005});
        do_pair(32'hFFFF_FFFB, 32'd0,         0, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
        do_pair(32'd100,       32'd7,         3, {32'h0000_000E, 32'h0000_0002}, {32'h0000_000E, 32'h0000_0002});

        // Second pair held valid through BUSY/DONE, captured on the first IDLE edge.
        @(negedge clk);
        da = 32'd1000; db = 32'd9;   va = 1'b1; vb = 1'b1;
        @(negedge clk);
        da = 32'hFFFF_FC18; db = 32'd7;
        wait_pulse(seen);
        e1 = edge_n;
        @(negedge clk);
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
        wait_pulse(seen);
        if (seen) begin
            chk("b2b_spacing", 64'(edge_n - e1), 64'd34);
            chk("b2b_literal_s", td_s, {32'hFFFF_FF72, 32'hFFFF_FFFA});
        end
        @(negedge clk);

        // Reset on the 10th step edge abandons the division.
        @(negedge clk);
        da = 32'd100; db = 32'd7; va = 1'b1; vb = 1'b1;
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_tready_s", {63'd0, ra_s & rb_s}, 64'd1);
        chk("midreset_tdata_u", td_u, 64'd0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom % 500 == 0);
            va  = ($urandom % 3 == 0);
            vb  = ($urandom % 3 == 0);
            da  = pick();
            db  = pick();
        end
        @(negedge clk);
        rst = 1'b0;
        va  = 1'b0;
        vb  = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
